muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
//
// PURPOSE
// - Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
// - Replaces the single-cycle combinational mul/div path.
// - Accepts one op per start pulse and computes iteratively, UNROLL bits per cycle.
// - Stalls the pipeline via busy; returns the result with a one-cycle valid pulse.
//
// PARAMETERS
// XLEN    32  operand/result width; must be 32 or 64
// UNROLL  1   iteration bits per cycle; must divide XLEN (1, 2, 4)
//
// PORTS
// clk           in   1     clock, all state on rising edge
// reset         in   1     synchronous, active-high
// start         in   1     launch op; accepted only when busy=0
// flush         in   1     abort in-flight op (pipeline flush)
// aluSelect     in   6     op code (MUL..REMU encodings below)
// rs1           in   XLEN  operand A
// rs2           in   XLEN  operand B
// busy          out  1     op in flight; stall EX
// result_valid  out  1     one-cycle pulse, result valid
// result        out  XLEN  result, held until next accepted op
//
// BEHAVIOUR
// - Encodings:
//   - MUL 101001, MULH 101010, MULHSU 101011, MULHU 101100
//   - DIV 101101, DIVU 101110, REM 101111, REMU 110000
// - Reset: state=IDLE; busy=0; result_valid=0; result=0; internal regs cleared.
// - FSM IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: start=1 with a valid op latches operands and op, sets busy=1 next cycle.
//   - CALC: run N=XLEN/UNROLL iterations, then go to DONE.
//   - DONE: result_valid=1 and busy=0 for exactly that cycle; result registered.
// - Latency, start accepted at cycle 0:
//   - Normal ops: valid at cycle N+1 (33 cycles for XLEN=32, UNROLL=1).
//   - Special cases skip CALC: valid at cycle 1.
// - Operands are sampled only on the accept cycle. rs1/rs2/aluSelect may change afterwards.
// - start while busy=1 is ignored. start in the DONE cycle is accepted: back-to-back ops allowed.
// - start with a non-M aluSelect: no accept, no valid, state unchanged.
// - Multiply:
//   - Operands take magnitudes per signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/MUL unsigned path.
//   - Shift-add into a 2*XLEN accumulator.
//   - Negate the product if the sign bits differ.
//   - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
// - Divide:
//   - Restoring, on magnitudes for DIV/REM.
//   - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
// - Special cases (no CALC):
//   - rs2==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   - Signed overflow (rs1 = most negative, rs2 = -1): DIV -> rs1; REM -> 0.
//   - MUL* with either operand 0 -> 0.
// - flush=1: state -> IDLE next cycle, busy=0; no result_valid; result keeps its previous value.
//   - flush has priority over start in the same cycle.
// - reset mid-operation behaves as flush and also clears result.
//
// STRUCTURE
// - Package muldiv_pkg holds:
//   - the 6-bit op code localparams (shared with the ALU decoder);
//   - the FSM state enum {IDLE, CALC, DONE};
//   - helper functions is_mul(op), is_signed_a(op), is_signed_b(op).
// - Sub-module muldiv_div_step: combinational single-bit restoring-divide step.
//   - Instantiated UNROLL times in a chain.
//   - The multiply shift-add step stays inline.
// - One iteration counter of width $clog2(XLEN/UNROLL)+1.
//
// TESTING
// - Reset, then MUL rs1=6, rs2=7 -> result=42, valid exactly at cycle 33, busy high cycles 1..32.
// - MULH rs1=-10, rs2=100000 -> 0xFFFFFFFF.
//   - MULHSU with the same operands -> 0xFFFFFFFF.
//   - MULHU rs1=50000, rs2=100000 -> 0x00000001.
// - Signed divide:
//   - DIV -100/25 -> 0xFFFFFFFC.
//   - REM -101/20 -> 0xFFFFFFFF (-1).
//   - DIVU 100/25 -> 4.
//   - REMU 101/20 -> 1.
// - Special cases, each with valid at cycle 1:
//   - DIV 123/0 -> 0xFFFFFFFF.
//   - REM 123/0 -> 123.
//   - DIV 0x80000000/-1 -> 0x80000000.
//   - REM 0x80000000/-1 -> 0.
// - Control:
//   - flush at cycle 10 of a DIV -> no valid, busy=0 at cycle 11, result unchanged.
//   - start while busy is ignored.
//   - start in the DONE cycle gives a back-to-back op.
// - Re-run the first two scenarios with XLEN=64, UNROLL=4 -> valid at cycle 17, 64-bit-correct results.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

   // Op codes, shared with the ALU decoder
   localparam logic [5:0] OP_MUL    = 6'b101001;
   localparam logic [5:0] OP_MULH   = 6'b101010;
   localparam logic [5:0] OP_MULHSU = 6'b101011;
   localparam logic [5:0] OP_MULHU  = 6'b101100;
   localparam logic [5:0] OP_DIV    = 6'b101101;
   localparam logic [5:0] OP_DIVU   = 6'b101110;
   localparam logic [5:0] OP_REM    = 6'b101111;
   localparam logic [5:0] OP_REMU   = 6'b110000;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   // The M encodings are contiguous, so a range check covers all eight
   function automatic logic is_m_op(input logic [5:0] op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

   function automatic logic is_mul(input logic [5:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   function automatic logic is_signed_a(input logic [5:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [5:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module muldiv_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] div_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] rem_sh;
   logic          fits;

   // Trial subtract; the partial remainder is always below the divisor, so XLEN+1 bits suffice
   always_comb begin
      rem_sh = {rem_i, quo_i[XLEN-1]};
      fits   = (rem_sh >= {1'b0, div_i});
      rem_o  = fits ? (rem_sh[XLEN-1:0] - div_i) : rem_sh[XLEN-1:0];
      quo_o  = {quo_i[XLEN-2:0], fits};
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit for EX. Works on operand magnitudes,
// UNROLL bits per cycle, and fixes the sign on the way into the result register.
// acc_q is shared: multiply uses it as {product_hi, multiplier/product_lo},
// divide uses it as {partial remainder, dividend/quotient}.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [5:0]      aluSelect,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   localparam int N     = XLEN / UNROLL;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   logic [5:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     opd_q, opd_d;      // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_sgn, b_sgn, spec_hit;
   logic [XLEN-1:0]     a_mag, b_mag, spec_val;
   logic [2*XLEN-1:0]   mul_acc, step_acc, prod;
   logic [XLEN:0]       mul_sum;
   logic [XLEN-1:0]     div_rem, div_quo, fin;
   logic                accept;

   // Restoring-divide chain, UNROLL steps per cycle
   for (genvar g = 0; g < UNROLL; g++) begin : g_div
      logic [XLEN-1:0] rem_in, quo_in, rem_out, quo_out;
      if (g == 0) begin : g_first
         assign rem_in = acc_q[2*XLEN-1:XLEN];
         assign quo_in = acc_q[XLEN-1:0];
      end else begin : g_next
         assign rem_in = g_div[g-1].rem_out;
         assign quo_in = g_div[g-1].quo_out;
      end
      muldiv_div_step #(.XLEN(XLEN)) u_step (
         .rem_i (rem_in),
         .quo_i (quo_in),
         .div_i (opd_q),
         .rem_o (rem_out),
         .quo_o (quo_out)
      );
   end
   assign div_rem = g_div[UNROLL-1].rem_out;
   assign div_quo = g_div[UNROLL-1].quo_out;

   // Operand magnitudes and the cases that bypass iteration
   always_comb begin
      a_sgn    = is_signed_a(aluSelect) & rs1[XLEN-1];
      b_sgn    = is_signed_b(aluSelect) & rs2[XLEN-1];
      a_mag    = a_sgn ? -rs1 : rs1;
      b_mag    = b_sgn ? -rs2 : rs2;
      spec_hit = 1'b0;
      spec_val = '0;
      if (is_mul(aluSelect)) begin
         spec_hit = (rs1 == '0) || (rs2 == '0);
      end else if (rs2 == '0) begin
         spec_hit = 1'b1;
         spec_val = ((aluSelect == OP_DIV) || (aluSelect == OP_DIVU)) ? '1 : rs1;
      end else if (((aluSelect == OP_DIV) || (aluSelect == OP_REM)) &&
                   (rs1 == MOST_NEG) && (rs2 == '1)) begin
         spec_hit = 1'b1;
         spec_val = (aluSelect == OP_DIV) ? rs1 : '0;
      end
   end

   // One iteration of shift-add multiply or chained divide, plus signed result fix-up
   always_comb begin
      mul_acc = acc_q;
      mul_sum = '0;
      for (int u = 0; u < UNROLL; u++) begin
         mul_sum = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, opd_q} : '0);
         mul_acc = {mul_sum, mul_acc[XLEN-1:1]};
      end
      step_acc = is_mul(op_q) ? mul_acc : {div_rem, div_quo};
      prod     = neg_q ? -step_acc : step_acc;
      if (is_mul(op_q))
         fin = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if ((op_q == OP_DIV) || (op_q == OP_DIVU))
         fin = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      else
         fin = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
   end

   // FSM next state, operand capture and result register update
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opd_d    = opd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      accept   = start && is_m_op(aluSelect) && (state_q != CALC);
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d  = DONE;
                  result_d = fin;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
         if (accept) begin
            op_d  = aluSelect;
            // remainder follows the dividend; quotient and product follow the sign XOR
            neg_d = ((aluSelect == OP_REM) || (aluSelect == OP_REMU)) ? a_sgn : (a_sgn ^ b_sgn);
            if (spec_hit) begin
               state_d  = DONE;
               result_d = spec_val;
            end else begin
               state_d = CALC;
               cnt_d   = CNT_W'(N);
               opd_d   = is_mul(aluSelect) ? a_mag : b_mag;
               acc_d   = {{XLEN{1'b0}}, (is_mul(aluSelect) ? b_mag : a_mag)};
            end
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opd_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opd_q    <= opd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy         = (state_q == CALC);
   assign result_valid = (state_q == DONE);
   assign result       = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a 32-bit/UNROLL=1 and a 64-bit/UNROLL=4 instance.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, flush, sel64;
   logic [5:0]  alu;
   logic [63:0] rs1, rs2;
   logic        busy32, valid32, busy64, valid64;
   logic [31:0] res32;
   logic [63:0] res64;
   logic        busy_s, valid_s;
   logic [63:0] result_s;
   logic [63:0] last_res;
   int          checks = 0;
   int          errors = 0;
   int          cyc, bcnt;
   logic        seen;

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(32), .UNROLL(1)) u_dut32 (
      .clk(clk), .reset(reset), .start(start & ~sel64), .flush(flush & ~sel64),
      .aluSelect(alu), .rs1(rs1[31:0]), .rs2(rs2[31:0]),
      .busy(busy32), .result_valid(valid32), .result(res32)
   );

   muldiv_seq #(.XLEN(64), .UNROLL(4)) u_dut64 (
      .clk(clk), .reset(reset), .start(start & sel64), .flush(flush & sel64),
      .aluSelect(alu), .rs1(rs1), .rs2(rs2),
      .busy(busy64), .result_valid(valid64), .result(res64)
   );

   assign busy_s   = sel64 ? busy64 : busy32;
   assign valid_s  = sel64 ? valid64 : valid32;
   assign result_s = sel64 ? res64 : {32'b0, res32};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present an op for one cycle (cycle 0), return at the negedge of cycle 1
   task automatic launch(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      start = 1'b1; alu = op; rs1 = a; rs2 = b;
      @(negedge clk);
      start = 1'b0;
      rs1 = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      alu = 6'($urandom);
   endtask

   // Wait (bounded) for result_valid, counting the cycle index and busy cycles
   task automatic wait_valid(input int c0, output int c, output int b);
      c = c0; b = 0;
      while (valid_s !== 1'b1 && c < 120) begin
         if (busy_s === 1'b1) b++;
         @(negedge clk);
         c++;
      end
   endtask

   task automatic run_op(input string tag, input logic [5:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int lat, input logic [63:0] exp);
      int c, bc;
      launch(op, a, b);
      wait_valid(1, c, bc);
      chk({tag, " latency"}, 64'(c), 64'(lat));
      chk({tag, " busy cycles"}, 64'(bc), 64'(lat - 1));
      chk({tag, " busy in done"}, {63'b0, busy_s}, 64'd0);
      chk({tag, " result"}, result_s, exp);
      @(negedge clk);
      chk({tag, " valid pulse"}, {63'b0, valid_s}, 64'd0);
      chk({tag, " result hold"}, result_s, exp);
      last_res = exp;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; sel64 = 1'b0;
      alu = '0; rs1 = '0; rs2 = '0; last_res = '0;
      repeat (3) @(negedge clk);
      chk("reset busy32", {63'b0, busy32}, 64'd0);
      chk("reset valid32", {63'b0, valid32}, 64'd0);
      chk("reset result32", {32'b0, res32}, 64'd0);
      chk("reset busy64", {63'b0, busy64}, 64'd0);
      chk("reset result64", res64, 64'd0);
      reset = 1'b0;

      // 32-bit iterative ops
      run_op("MUL 6*7",       OP_MUL,    64'd6,           64'd7,           33, 64'd42);
      run_op("MULH -10*1e5",  OP_MULH,   64'hFFFF_FFF6,   64'd100000,      33, 64'hFFFF_FFFF);
      run_op("MULHSU -10*1e5",OP_MULHSU, 64'hFFFF_FFF6,   64'd100000,      33, 64'hFFFF_FFFF);
      run_op("MULHU 5e4*1e5", OP_MULHU,  64'd50000,       64'd100000,      33, 64'h0000_0001);
      run_op("MULH minneg^2", OP_MULH,   64'h8000_0000,   64'h8000_0000,   33, 64'h4000_0000);
      run_op("MUL ones*ones", OP_MUL,    64'hFFFF_FFFF,   64'hFFFF_FFFF,   33, 64'h0000_0001);
      run_op("DIV -100/25",   OP_DIV,    64'hFFFF_FF9C,   64'd25,          33, 64'hFFFF_FFFC);
      run_op("REM -101/20",   OP_REM,    64'hFFFF_FF9B,   64'd20,          33, 64'hFFFF_FFFF);
      run_op("DIVU 100/25",   OP_DIVU,   64'd100,         64'd25,          33, 64'd4);
      run_op("REMU 101/20",   OP_REMU,   64'd101,         64'd20,          33, 64'd1);
      run_op("DIV 7/-2",      OP_DIV,    64'd7,           64'hFFFF_FFFE,   33, 64'hFFFF_FFFD);
      run_op("REM 7/-2",      OP_REM,    64'd7,           64'hFFFF_FFFE,   33, 64'd1);

      // special cases, result one cycle after accept
      run_op("DIV 123/0",     OP_DIV,    64'd123,         64'd0,           1,  64'hFFFF_FFFF);
      run_op("REM 123/0",     OP_REM,    64'd123,         64'd0,           1,  64'd123);
      run_op("DIV ovf",       OP_DIV,    64'h8000_0000,   64'hFFFF_FFFF,   1,  64'h8000_0000);
      run_op("REM ovf",       OP_REM,    64'h8000_0000,   64'hFFFF_FFFF,   1,  64'd0);
      run_op("MULHU 0*5",     OP_MULHU,  64'd0,           64'd5,           1,  64'd0);
      run_op("DIVU 77/1",     OP_DIVU,   64'd77,          64'd1,           33, 64'd77);

      // flush at cycle 10: idle at cycle 11, no valid, result unchanged
      launch(OP_DIV, 64'd1000, 64'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", {63'b0, busy_s}, 64'd0);
      seen = 1'b0;
      repeat (40) begin
         if (valid_s === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      chk("flush no valid", {63'b0, seen}, 64'd0);
      chk("flush result hold", result_s, last_res);

      // start while busy is ignored
      launch(OP_DIVU, 64'd100, 64'd25);
      repeat (4) @(negedge clk);
      start = 1'b1; alu = OP_MUL; rs1 = 64'd6; rs2 = 64'd7;
      @(negedge clk);
      start = 1'b0;
      wait_valid(6, cyc, bcnt);
      chk("busy-start latency", 64'(cyc), 64'd33);
      chk("busy-start result", result_s, 64'd4);
      @(negedge clk);
      seen = 1'b0;
      repeat (40) begin
         if (valid_s === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      chk("busy-start no 2nd op", {63'b0, seen}, 64'd0);

      // start in the DONE cycle gives a back-to-back op
      launch(OP_MUL, 64'd6, 64'd7);
      wait_valid(1, cyc, bcnt);
      chk("b2b first latency", 64'(cyc), 64'd33);
      chk("b2b first result", result_s, 64'd42);
      start = 1'b1; alu = OP_DIVU; rs1 = 64'd101; rs2 = 64'd20;
      @(negedge clk);
      start = 1'b0;
      chk("b2b second busy", {63'b0, busy_s}, 64'd1);
      wait_valid(1, cyc, bcnt);
      chk("b2b second latency", 64'(cyc), 64'd33);
      chk("b2b second result", result_s, 64'd5);
      @(negedge clk);
      last_res = 64'd5;

      // non-M op code is not accepted
      @(negedge clk);
      start = 1'b1; alu = 6'b000011; rs1 = 64'd5; rs2 = 64'd5;
      @(negedge clk);
      start = 1'b0;
      chk("non-M busy", {63'b0, busy_s}, 64'd0);
      seen = 1'b0;
      repeat (5) begin
         if (valid_s === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      chk("non-M no valid", {63'b0, seen}, 64'd0);
      chk("non-M result hold", result_s, last_res);

      // 64-bit, UNROLL=4
      sel64 = 1'b1;
      run_op("64 MUL 6*7",      OP_MUL,   64'd6,                  64'd7,      17, 64'd42);
      run_op("64 MULH -10*1e5", OP_MULH,  64'hFFFF_FFFF_FFFF_FFF6, 64'd100000, 17, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("64 MULHU ones*2", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,      17, 64'd1);
      run_op("64 DIV -100/25",  OP_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd25,     17, 64'hFFFF_FFFF_FFFF_FFFC);
      run_op("64 REMU big",     OP_REMU,  64'h1_0000_0005,        64'h1_0000_0000, 17, 64'd5);

      // reset mid-operation aborts and clears result
      sel64 = 1'b0;
      launch(OP_MUL, 64'd6, 64'd7);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid reset busy", {63'b0, busy_s}, 64'd0);
      chk("mid reset valid", {63'b0, valid_s}, 64'd0);
      chk("mid reset result", result_s, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
